// File: rtl/wfid_slot_table_demux.sv
// Write-side slot table for the issue-stage 40:1 wavefront select mux.
// Decodes a wavefront ID into one of 40 per-slot registers, tracks per-slot
// valid bits and an occupancy count, and flags out-of-range IDs.
module wfid_slot_table_demux #(
   parameter int unsigned              WORD_WIDTH = 12,
   parameter logic [WORD_WIDTH-1:0]    RESET_VAL  = '0
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              wr_en,
   input  logic [5:0]                        wr_wfid,
   input  logic [WORD_WIDTH-1:0]             wr_data,
   input  logic                              clr_en,
   input  logic [5:0]                        clr_wfid,
   output logic [40*WORD_WIDTH-1:0]          out_data,
   output logic [39:0]                       out_valid,
   output logic [5:0]                        valid_count,
   output logic                              id_err
);

   localparam int unsigned NUM_SLOTS = 40;
   localparam int unsigned ID_W      = 6;
   localparam int unsigned CNT_W     = 6;

   logic [NUM_SLOTS-1:0] wr_sel;
   logic [NUM_SLOTS-1:0] clr_sel;
   logic                 wr_bad;
   logic                 clr_bad;
   logic                 wr_inc;
   logic                 clr_dec;
   logic [CNT_W-1:0]     count_next;

   // One-hot decode of both strobes; IDs 40..63 select nothing.
   always_comb begin
      wr_sel  = '0;
      clr_sel = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         wr_sel[i]  = wr_en  && (wr_wfid  == ID_W'(i));
         clr_sel[i] = clr_en && (clr_wfid == ID_W'(i));
      end
   end

   // Occupancy deltas; a clear shadowed by a same-slot write does not count.
   always_comb begin
      wr_bad     = wr_en  && (wr_wfid  >= ID_W'(NUM_SLOTS));
      clr_bad    = clr_en && (clr_wfid >= ID_W'(NUM_SLOTS));
      wr_inc     = |(wr_sel & ~out_valid);
      clr_dec    = |(clr_sel & out_valid & ~wr_sel);
      count_next = valid_count + CNT_W'(wr_inc) - CNT_W'(clr_dec);
   end

   // Slot data registers: write takes priority over clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= {NUM_SLOTS{RESET_VAL}};
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_sel[i]) begin
               out_data[i*WORD_WIDTH +: WORD_WIDTH] <= wr_data;
            end else if (clr_sel[i]) begin
               out_data[i*WORD_WIDTH +: WORD_WIDTH] <= RESET_VAL;
            end
         end
      end
   end

   // Valid vector, occupancy count and out-of-range error pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid   <= '0;
         valid_count <= '0;
         id_err      <= 1'b0;
      end else begin
         out_valid   <= (out_valid & ~clr_sel) | wr_sel;
         valid_count <= count_next;
         id_err      <= wr_bad || clr_bad;
      end
   end

endmodule

// File: tb/tb_wfid_slot_table_demux.sv
// Self-checking bench for wfid_slot_table_demux: directed scenarios plus a
// randomized run, all compared against an array-based slot table model.
module tb_wfid_slot_table_demux;

   localparam int unsigned W = 12;

   logic            clk;
   logic            rst_n;
   logic            wr_en;
   logic [5:0]      wr_wfid;
   logic [W-1:0]    wr_data;
   logic            clr_en;
   logic [5:0]      clr_wfid;
   logic [40*W-1:0] out_data;
   logic [39:0]     out_valid;
   logic [5:0]      valid_count;
   logic            id_err;

   int vectors = 0;
   int errors  = 0;

   // Reference model: plain per-slot arrays.
   logic [W-1:0] m_data [40];
   logic [39:0]  m_valid;
   logic         m_err;

   wfid_slot_table_demux #(.WORD_WIDTH(W), .RESET_VAL('0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_wfid     (wr_wfid),
      .wr_data     (wr_data),
      .clr_en      (clr_en),
      .clr_wfid    (clr_wfid),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .valid_count (valid_count),
      .id_err      (id_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [40*W-1:0] model_bus();
      logic [40*W-1:0] b;
      for (int i = 0; i < 40; i++) b[i*W +: W] = m_data[i];
      return b;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < 40; i++) c += int'(m_valid[i]);
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 40; i++) m_data[i] = '0;
      m_valid = '0;
      m_err   = 1'b0;
   endtask

   // Drive one cycle of strobes, then advance the model with the same rules.
   task automatic cycle(input logic we, input logic [5:0] wid, input logic [W-1:0] wd,
                        input logic ce, input logic [5:0] cid);
      @(negedge clk);
      wr_en = we; wr_wfid = wid; wr_data = wd;
      clr_en = ce; clr_wfid = cid;
      @(posedge clk);
      m_err = (we && wid >= 6'd40) || (ce && cid >= 6'd40);
      if (ce && cid < 6'd40) begin
         m_valid[cid] = 1'b0;
         m_data[cid]  = '0;
      end
      if (we && wid < 6'd40) begin
         m_valid[wid] = 1'b1;
         m_data[wid]  = wd;
      end
      #1;
   endtask

   task automatic test_reset();
      vectors++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
      vectors++;
      if (out_valid !== 40'd0) begin errors++; $display("FAIL reset_valid got %h exp 0", out_valid); end
      vectors++;
      if (valid_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", valid_count); end
      vectors++;
      if (id_err !== 1'b0) begin errors++; $display("FAIL reset_id_err got %b exp 0", id_err); end
   endtask

   task automatic test_basic_write(input string tag);
      logic [39:0] exp_v;
      exp_v = 40'd1 | (40'd1 << 39);
      cycle(1'b1, 6'd0,  12'h5A5, 1'b0, 6'd0);
      cycle(1'b1, 6'd39, 12'hABC, 1'b0, 6'd0);
      vectors++;
      if (out_data[11:0] !== 12'h5A5) begin errors++; $display("FAIL %s slot0 got %h exp 5a5", tag, out_data[11:0]); end
      vectors++;
      if (out_data[479:468] !== 12'hABC) begin errors++; $display("FAIL %s slot39 got %h exp abc", tag, out_data[479:468]); end
      vectors++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL %s valid got %h exp %h", tag, out_valid, exp_v); end
      vectors++;
      if (valid_count !== 6'd2) begin errors++; $display("FAIL %s count got %0d exp 2", tag, valid_count); end
      vectors++;
      if (id_err !== 1'b0) begin errors++; $display("FAIL %s id_err got %b exp 0", tag, id_err); end
   endtask

   task automatic test_overwrite();
      int c0;
      c0 = model_count();
      cycle(1'b1, 6'd7, 12'h111, 1'b0, 6'd0);
      cycle(1'b1, 6'd7, 12'h222, 1'b0, 6'd0);
      vectors++;
      if (out_data[7*W +: W] !== 12'h222) begin errors++; $display("FAIL overwrite_slot7 got %h exp 222", out_data[7*W +: W]); end
      vectors++;
      if (int'(valid_count) !== c0 + 1) begin errors++; $display("FAIL overwrite_count got %0d exp %0d", valid_count, c0 + 1); end
   endtask

   task automatic test_same_slot();
      int c0;
      cycle(1'b1, 6'd3, 12'h033, 1'b0, 6'd0);
      c0 = model_count();
      cycle(1'b1, 6'd3, 12'h0FF, 1'b1, 6'd3);
      vectors++;
      if (out_data[3*W +: W] !== 12'h0FF) begin errors++; $display("FAIL same_slot_data got %h exp 0ff", out_data[3*W +: W]); end
      vectors++;
      if (out_valid[3] !== 1'b1) begin errors++; $display("FAIL same_slot_valid got %b exp 1", out_valid[3]); end
      vectors++;
      if (int'(valid_count) !== c0) begin errors++; $display("FAIL same_slot_count got %0d exp %0d", valid_count, c0); end
      cycle(1'b0, 6'd0, 12'h000, 1'b1, 6'd3);
      vectors++;
      if (out_data[3*W +: W] !== 12'h000) begin errors++; $display("FAIL clear3_data got %h exp 0", out_data[3*W +: W]); end
      vectors++;
      if (out_valid[3] !== 1'b0) begin errors++; $display("FAIL clear3_valid got %b exp 0", out_valid[3]); end
      vectors++;
      if (int'(valid_count) !== c0 - 1) begin errors++; $display("FAIL clear3_count got %0d exp %0d", valid_count, c0 - 1); end
   endtask

   task automatic test_bad_id();
      int c0;
      cycle(1'b1, 6'd2, 12'h2A2, 1'b0, 6'd0);
      c0 = model_count();
      cycle(1'b1, 6'd45, 12'hFFF, 1'b1, 6'd2);
      vectors++;
      if (id_err !== 1'b1) begin errors++; $display("FAIL bad_id_err got %b exp 1", id_err); end
      vectors++;
      if (out_valid[2] !== 1'b0 || out_data[2*W +: W] !== 12'h000) begin
         errors++; $display("FAIL bad_id_clr2 got v=%b d=%h exp v=0 d=0", out_valid[2], out_data[2*W +: W]);
      end
      vectors++;
      if (int'(valid_count) !== c0 - 1) begin errors++; $display("FAIL bad_id_count got %0d exp %0d", valid_count, c0 - 1); end
      vectors++;
      if (out_data !== model_bus()) begin errors++; $display("FAIL bad_id_bus got %h exp %h", out_data, model_bus()); end
      cycle(1'b0, 6'd0, 12'h000, 1'b0, 6'd0);
      vectors++;
      if (id_err !== 1'b0) begin errors++; $display("FAIL bad_id_pulse got %b exp 0", id_err); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 40; i++) cycle(1'b1, 6'(i), W'($urandom), 1'b0, 6'd0);
      vectors++;
      if (valid_count !== 6'd40) begin errors++; $display("FAIL fill_count got %0d exp 40", valid_count); end
      vectors++;
      if (out_valid !== {40{1'b1}}) begin errors++; $display("FAIL fill_valid got %h exp all ones", out_valid); end
      vectors++;
      if (out_data !== model_bus()) begin errors++; $display("FAIL fill_bus got %h exp %h", out_data, model_bus()); end
      cycle(1'b1, 6'd5, 12'h555, 1'b0, 6'd0);
      vectors++;
      if (valid_count !== 6'd40) begin errors++; $display("FAIL full_rewrite_count got %0d exp 40", valid_count); end
      for (int i = 0; i < 40; i++) cycle(1'b0, 6'd0, 12'h000, 1'b1, 6'(i));
      vectors++;
      if (valid_count !== 6'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", valid_count); end
      vectors++;
      if (out_data !== '0) begin errors++; $display("FAIL drain_bus got %h exp 0", out_data); end
      cycle(1'b0, 6'd0, 12'h000, 1'b1, 6'd0);
      vectors++;
      if (valid_count !== 6'd0) begin errors++; $display("FAIL extra_clear_count got %0d exp 0", valid_count); end
   endtask

   task automatic test_random(input int n);
      logic          we, ce;
      logic [5:0]    wid, cid;
      logic [W-1:0]  wd;
      for (int k = 0; k < n; k++) begin
         we  = ($urandom_range(0, 99) < 60);
         ce  = ($urandom_range(0, 99) < 45);
         wid = 6'($urandom_range(0, 47));
         cid = ($urandom_range(0, 3) == 0) ? wid : 6'($urandom_range(0, 47));
         wd  = W'($urandom);
         cycle(we, wid, wd, ce, cid);
         vectors++;
         if (out_data !== model_bus()) begin errors++; $display("FAIL rand_bus cyc %0d got %h exp %h", k, out_data, model_bus()); end
         vectors++;
         if (out_valid !== m_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %h exp %h", k, out_valid, m_valid); end
         vectors++;
         if (int'(valid_count) !== model_count()) begin errors++; $display("FAIL rand_count cyc %0d got %0d exp %0d", k, valid_count, model_count()); end
         vectors++;
         if (id_err !== m_err) begin errors++; $display("FAIL rand_id_err cyc %0d got %b exp %b", k, id_err, m_err); end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 6'(i + 10), W'($urandom), 1'b0, 6'd0);
      @(negedge clk);
      wr_en = 1'b1; wr_wfid = 6'd20; wr_data = 12'h777;
      clr_en = 1'b0; clr_wfid = 6'd0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if (out_data !== '0 || out_valid !== 40'd0 || valid_count !== 6'd0 || id_err !== 1'b0) begin
         errors++; $display("FAIL async_reset got v=%h c=%0d e=%b exp all zero", out_valid, valid_count, id_err);
      end
      @(posedge clk);
      #1;
      vectors++;
      if (out_valid !== 40'd0 || out_data !== '0) begin
         errors++; $display("FAIL async_reset_hold got v=%h exp 0", out_valid);
      end
      @(negedge clk);
      wr_en = 1'b0;
      rst_n = 1'b1;
      test_basic_write("post_reset");
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_wfid = '0; wr_data = '0;
      clr_en = 1'b0; clr_wfid = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_basic_write("basic");
      test_overwrite();
      test_same_slot();
      test_bad_id();
      test_fill_drain();
      test_random(400);
      test_async_reset();
      test_random(100);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
